// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking-lot gate arbiter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOOR   = 2'd1,
    REJECT = 2'd2
  } state_e;

  typedef enum logic {
    ENTRY = 1'b0,
    EXIT  = 1'b1
  } rr_side_e;

  localparam int DEF_NUM_SLOTS    = 4;
  localparam int DEF_SLOT_W       = 2;
  localparam int DEF_DOOR_TICKS   = 4;
  localparam int DEF_REJECT_TICKS = 2;

  // Counter must hold the larger of the two tick budgets.
  function automatic int tick_cnt_w(input int door_ticks, input int reject_ticks);
    int max_ticks;
    max_ticks = (door_ticks > reject_ticks) ? door_ticks : reject_ticks;
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/slot_alloc.sv
// Lowest-numbered free slot priority encoder over the occupancy vector.
module slot_alloc #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    free_idx,
  output logic                 any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        free_idx = SLOT_W'(i);
        any_free = 1'b1;
      end else begin
        free_idx = free_idx;
      end
    end
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Entry/exit arbiter sharing one door and one occupancy register.
// Optional PARK_STATS_EN adds saturating entry/exit/reject counters.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
  parameter int SLOT_W       = DEF_SLOT_W,
  parameter int DOOR_TICKS   = DEF_DOOR_TICKS,
  parameter int REJECT_TICKS = DEF_REJECT_TICKS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    granted_slot,
  output logic                 grant_entry,
  output logic                 grant_exit,
  output logic                 reject,
  output logic                 exit_err,
  output logic                 door_open,
  output logic                 full_flag,
  output logic                 busy
`ifdef PARK_STATS_EN
  ,
  output logic [7:0]           entry_count,
  output logic [7:0]           exit_count,
  output logic [7:0]           reject_count
`endif
);

  localparam int CNT_W = tick_cnt_w(DOOR_TICKS, REJECT_TICKS);

  state_e               state_q, state_d;
  rr_side_e             rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [SLOT_W-1:0]    gslot_q, gslot_d;
  logic                 ge_q, ge_d, gx_q, gx_d, rej_q, rej_d, err_q, err_d;
  logic                 door_q;
  logic [SLOT_W-1:0]    free_idx;
  logic                 any_free;
  logic                 pick_entry;
  logic                 pick_exit;

  slot_alloc #(
    .NUM_SLOTS(NUM_SLOTS),
    .SLOT_W   (SLOT_W)
  ) u_slot_alloc (
    .occupancy(occ_q),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  // On a tie the side not served last wins.
  assign pick_entry = entry_req && (!exit_req || (rr_q == EXIT));
  assign pick_exit  = exit_req && !pick_entry;

  // Next-state, occupancy update and pulse generation.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    occ_d   = occ_q;
    gslot_d = gslot_q;
    ge_d    = 1'b0;
    gx_d    = 1'b0;
    rej_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_entry) begin
          rr_d = ENTRY;
          if (any_free) begin
            occ_d[free_idx] = 1'b1;
            gslot_d         = free_idx;
            ge_d            = 1'b1;
            state_d         = DOOR;
          end else begin
            rej_d   = 1'b1;
            state_d = REJECT;
          end
        end else if (pick_exit) begin
          rr_d = EXIT;
          if (occ_q[exit_slot]) begin
            occ_d[exit_slot] = 1'b0;
            gx_d             = 1'b1;
            state_d          = DOOR;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DOOR: begin
        if (tick) begin
          if (cnt_q == CNT_W'(DOOR_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      REJECT: begin
        if (tick) begin
          if (cnt_q == CNT_W'(REJECT_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, occupancy and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= EXIT;
      cnt_q   <= '0;
      occ_q   <= '0;
      gslot_q <= '0;
      ge_q    <= 1'b0;
      gx_q    <= 1'b0;
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      gslot_q <= gslot_d;
      ge_q    <= ge_d;
      gx_q    <= gx_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
      door_q  <= (state_d == DOOR);
    end
  end

  assign occupancy    = occ_q;
  assign granted_slot = gslot_q;
  assign grant_entry  = ge_q;
  assign grant_exit   = gx_q;
  assign reject       = rej_q;
  assign exit_err     = err_q;
  assign door_open    = door_q;
  assign full_flag    = &occ_q;
  assign busy         = (state_q != IDLE);

`ifdef PARK_STATS_EN
  logic [7:0] entry_cnt_q, exit_cnt_q, reject_cnt_q;

  // Saturating event counters, updated together with their pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_cnt_q  <= 8'd0;
      exit_cnt_q   <= 8'd0;
      reject_cnt_q <= 8'd0;
    end else begin
      if (ge_d && (entry_cnt_q != 8'hFF)) entry_cnt_q <= entry_cnt_q + 8'd1;
      if (gx_d && (exit_cnt_q != 8'hFF)) exit_cnt_q <= exit_cnt_q + 8'd1;
      if (rej_d && (reject_cnt_q != 8'hFF)) reject_cnt_q <= reject_cnt_q + 8'd1;
    end
  end

  assign entry_count  = entry_cnt_q;
  assign exit_count   = exit_cnt_q;
  assign reject_count = reject_cnt_q;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: vector table, directed corners, random vs model.
module tb_parking_gate_arbiter;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int DT = 4;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick;
  logic          entry_req;
  logic          exit_req;
  logic [SW-1:0] exit_slot;
  logic [NS-1:0] occupancy;
  logic [SW-1:0] granted_slot;
  logic          grant_entry, grant_exit, reject, exit_err;
  logic          door_open, full_flag, busy;
`ifdef PARK_STATS_EN
  logic [7:0]    entry_count, exit_count, reject_count;
`endif

  parking_gate_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .exit_slot   (exit_slot),
    .occupancy   (occupancy),
    .granted_slot(granted_slot),
    .grant_entry (grant_entry),
    .grant_exit  (grant_exit),
    .reject      (reject),
    .exit_err    (exit_err),
    .door_open   (door_open),
    .full_flag   (full_flag),
    .busy        (busy)
`ifdef PARK_STATS_EN
    ,
    .entry_count (entry_count),
    .exit_count  (exit_count),
    .reject_count(reject_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: door/reject modelled as "ticks remaining", slots as a bit array.
  bit m_occ[NS];
  int m_mode;        // 0 idle, 1 door, 2 reject
  int m_left;
  int m_gslot;
  bit m_entry_turn;  // entry wins the next tie
  bit m_ge, m_gx, m_rej, m_err;
  int m_ec, m_xc, m_rc;

  typedef struct {
    int e, x, s, t;
    int occ, gs, ge, gx, rej, err, door, full, busy;
  } vec_t;
  vec_t tbl[17];

  function automatic logic [12:0] pack(int occ, int gs, int ge, int gx, int rej,
                                       int err, int door, int full, int bsy);
    return {occ[3:0], gs[1:0], ge[0], gx[0], rej[0], err[0], door[0], full[0], bsy[0]};
  endfunction

  function automatic logic [12:0] dut_vec();
    return pack(int'(occupancy), int'(granted_slot), int'(grant_entry), int'(grant_exit),
                int'(reject), int'(exit_err), int'(door_open), int'(full_flag), int'(busy));
  endfunction

  function automatic logic [12:0] model_vec();
    int occ = 0;
    int cnt = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_occ[i]) begin
        occ += (1 << i);
        cnt++;
      end
    end
    return pack(occ, m_gslot, int'(m_ge), int'(m_gx), int'(m_rej), int'(m_err),
                (m_mode == 1) ? 1 : 0, (cnt == NS) ? 1 : 0, (m_mode != 0) ? 1 : 0);
  endfunction

  task automatic check_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(string name, logic [12:0] exp);
    logic [12:0] act;
    act = dut_vec();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (occ,gs,ge,gx,rej,err,door,full,busy) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_occ[i] = 1'b0;
    m_mode = 0;
    m_left = 0;
    m_gslot = 0;
    m_entry_turn = 1'b1;
    m_ge = 1'b0; m_gx = 1'b0; m_rej = 1'b0; m_err = 1'b0;
    m_ec = 0; m_xc = 0; m_rc = 0;
  endtask

  task automatic model_step(int e, int x, int s, int t);
    int f;
    m_ge = 1'b0; m_gx = 1'b0; m_rej = 1'b0; m_err = 1'b0;
    if (m_mode == 0) begin
      if (e != 0 && (x == 0 || m_entry_turn)) begin
        m_entry_turn = 1'b0;
        f = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_occ[i]) f = i;
        if (f >= 0) begin
          m_occ[f] = 1'b1;
          m_gslot = f;
          m_ge = 1'b1;
          m_mode = 1;
          m_left = DT;
          if (m_ec < 255) m_ec++;
        end else begin
          m_rej = 1'b1;
          m_mode = 2;
          m_left = RT;
          if (m_rc < 255) m_rc++;
        end
      end else if (x != 0) begin
        m_entry_turn = 1'b1;
        if (m_occ[s]) begin
          m_occ[s] = 1'b0;
          m_gx = 1'b1;
          m_mode = 1;
          m_left = DT;
          if (m_xc < 255) m_xc++;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (t != 0) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  endtask

  task automatic step(int e, int x, int s, int t);
    entry_req = e[0];
    exit_req  = x[0];
    exit_slot = s[SW-1:0];
    tick      = t[0];
    model_step(e, x, s, t);
    @(posedge clk);
    #1;
    check_vec("model", model_vec());
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    entry_req = 1'b0; exit_req = 1'b0; exit_slot = '0; tick = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_vec("reset", pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ticks, n, t, er, xr, xs;

    //            e  x  s  t  occ gs ge gx rj er dr fl by
    tbl[0]  = '{1, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1, 0, 1};
    tbl[1]  = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 0, 1};
    tbl[2]  = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 3,  1, 1, 0, 0, 0, 1, 0, 1};
    tbl[7]  = '{0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 1, 0, 1};
    tbl[9]  = '{0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 1, 3,  1, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 2, 0, 3,  1, 0, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 2,  1, 0, 1, 0, 0, 1, 0, 1};
    tbl[13] = '{0, 0, 0, 1, 2,  1, 0, 0, 0, 0, 1, 0, 1};
    tbl[14] = '{0, 0, 0, 1, 2,  1, 0, 0, 0, 0, 1, 0, 1};
    tbl[15] = '{0, 0, 0, 1, 2,  1, 0, 0, 0, 0, 1, 0, 1};
    tbl[16] = '{0, 0, 0, 1, 2,  1, 0, 0, 0, 0, 0, 0, 0};

    reset_n = 1'b0;
    entry_req = 1'b0; exit_req = 1'b0; exit_slot = '0; tick = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].e, tbl[i].x, tbl[i].s, tbl[i].t);
      check_vec($sformatf("table[%0d]", i),
                pack(tbl[i].occ, tbl[i].gs, tbl[i].ge, tbl[i].gx, tbl[i].rej,
                     tbl[i].err, tbl[i].door, tbl[i].full, tbl[i].busy));
    end

    // Fill the lot; door must stay open for exactly DT ticks each time.
    do_reset();
    for (int k = 0; k < NS; k++) begin
      step(1, 0, 0, 0);
      check_int("fill_slot", int'(granted_slot), k);
      check_int("fill_grant", int'(grant_entry), 1);
      ticks = 0;
      n = 0;
      while (door_open && n < 40) begin
        t = n % 2;
        step(0, 0, 0, t);
        ticks += t;
        n++;
      end
      check_int("door_ticks", ticks, DT);
      check_int("fill_occ", int'(occupancy), (1 << (k + 1)) - 1);
    end
    check_int("full_flag", int'(full_flag), 1);

    // Full lot: reject, REJECT for RT ticks, reject again while still requested.
    step(1, 0, 0, 0);
    check_int("reject_pulse", int'(reject), 1);
    step(1, 0, 0, 1);
    check_int("reject_hold_busy", int'(busy), 1);
    check_int("reject_hold_pulse", int'(reject), 0);
    step(1, 0, 0, 1);
    check_int("reject_done_busy", int'(busy), 0);
    step(1, 0, 0, 0);
    check_int("reject_again", int'(reject), 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_int("reject_idle", int'(busy), 0);

    // 1011 with simultaneous requests: entry first, exit after the door closes.
    step(0, 1, 2, 0);
    check_int("mk1011_occ", int'(occupancy), 4'hB);
    repeat (DT) step(0, 0, 0, 1);
    step(1, 1, 1, 0);
    check_int("tie_entry_grant", int'(grant_entry), 1);
    check_int("tie_entry_slot", int'(granted_slot), 2);
    check_int("tie_entry_occ", int'(occupancy), 4'hF);
    repeat (DT) step(0, 1, 1, 1);
    check_int("tie_door_closed", int'(door_open), 0);
    step(0, 1, 1, 0);
    check_int("tie_exit_grant", int'(grant_exit), 1);
    check_int("tie_exit_occ", int'(occupancy), 4'hD);

    // 0101, exit of a free slot -> exit_err, nothing else changes.
    repeat (DT) step(0, 0, 0, 1);
    step(0, 1, 3, 0);
    check_int("mk0101_occ", int'(occupancy), 4'h5);
    repeat (DT) step(0, 0, 0, 1);
    step(0, 1, 1, 0);
    check_int("err_pulse", int'(exit_err), 1);
    check_int("err_occ", int'(occupancy), 4'h5);
    check_int("err_door", int'(door_open), 0);
    check_int("err_busy", int'(busy), 0);

    // Asynchronous reset in the middle of DOOR.
    step(1, 0, 0, 0);
    check_int("pre_rst_slot", int'(granted_slot), 1);
    step(0, 0, 0, 1);
    entry_req = 1'b0; exit_req = 1'b0; tick = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_vec("async_reset", pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    tick = 1'b0;
    reset_n = 1'b1;
    step(1, 1, 0, 0);
    check_int("post_rst_entry", int'(grant_entry), 1);
    check_int("post_rst_exit", int'(grant_exit), 0);
    check_int("post_rst_slot", int'(granted_slot), 0);
    repeat (DT) step(0, 0, 0, 1);

`ifdef PARK_STATS_EN
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 0, 0);
      repeat (DT) step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      repeat (DT) step(0, 0, 0, 1);
    end
    check_int("entry_count_sat", int'(entry_count), 255);
    check_int("exit_count_sat", int'(exit_count), 255);
    check_int("reject_count", int'(reject_count), m_rc);
`endif

    // Randomized traffic against the model; requesters hold until answered.
    er = 0; xr = 0; xs = 0;
    for (int i = 0; i < 2000; i++) begin
      if (er == 0 && $urandom_range(3) == 0) er = 1;
      if (xr == 0 && $urandom_range(3) == 0) begin
        xr = 1;
        xs = int'($urandom_range(NS - 1));
      end
      t = ($urandom_range(2) == 0) ? 1 : 0;
      step(er, xr, xs, t);
      if (m_ge || m_rej) er = 0;
      if (m_gx || m_err) xr = 0;
    end

`ifdef PARK_STATS_EN
    check_int("rand_entry_count", int'(entry_count), m_ec);
    check_int("rand_exit_count", int'(exit_count), m_xc);
    check_int("rand_reject_count", int'(reject_count), m_rc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
